// File: rtl/snn_noc_pkg.sv
// Shared spike-packet field layout and config-select encodings
// for the cluster network endpoints.
package snn_noc_pkg;

   localparam int PKT_W   = 24;
   localparam int ADDR_W  = 12;
   localparam int SRC_MSB = 23;
   localparam int SRC_LSB = 12;
   localparam int DST_MSB = 11;
   localparam int DST_LSB = 0;
   localparam int CL_MSB  = 11;
   localparam int CL_LSB  = 4;
   localparam int NRN_MSB = 3;
   localparam int NRN_LSB = 0;
   localparam int CL_W    = CL_MSB - CL_LSB + 1;
   localparam int NRN_W   = NRN_MSB - NRN_LSB + 1;

   typedef logic [PKT_W-1:0] pkt_t;

   typedef enum logic {
      CFG_CAM    = 1'b0,
      CFG_WEIGHT = 1'b1
   } cfg_sel_e;

   function automatic logic [ADDR_W-1:0] pkt_src(input pkt_t p);
      return p[SRC_MSB:SRC_LSB];
   endfunction

   function automatic logic [ADDR_W-1:0] pkt_dst(input pkt_t p);
      return p[DST_MSB:DST_LSB];
   endfunction

   function automatic logic [CL_W-1:0] dst_cluster(
      input logic [ADDR_W-1:0] d
   );
      return d[CL_MSB:CL_LSB];
   endfunction

   function automatic logic [NRN_W-1:0] dst_neuron(
      input logic [ADDR_W-1:0] d
   );
      return d[NRN_MSB:NRN_LSB];
   endfunction

endpackage

// File: rtl/spike_packet_receiver_if.sv
// Packet-in and accumulate-out handshakes of the spike receiver.
// The receiver is the slave; the network/accumulator side is master.
interface spike_packet_receiver_if #(
   parameter int WEIGHT_W = 16
);
   import snn_noc_pkg::*;

   pkt_t                       pkt_in;
   logic                       pkt_valid;
   logic                       pkt_ready;
   logic                       acc_valid;
   logic                       acc_ready;
   logic [NRN_W-1:0]           acc_neuron;
   logic signed [WEIGHT_W-1:0] acc_weight;

   modport slave (
      input  pkt_in,
      input  pkt_valid,
      output pkt_ready,
      output acc_valid,
      input  acc_ready,
      output acc_neuron,
      output acc_weight
   );

   modport master (
      output pkt_in,
      output pkt_valid,
      input  pkt_ready,
      input  acc_valid,
      output acc_ready,
      input  acc_neuron,
      input  acc_weight
   );

endinterface

// File: rtl/spike_pkt_fifo.sv
// Synchronous packet buffer with flush; pointers carry a wrap bit
// so full and empty are told apart without a counter.
module spike_pkt_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 24
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]  wp;
   logic [AW:0]  rp;
   logic [W-1:0] mem [DEPTH];
   logic         do_push;
   logic         do_pop;

   assign empty   = (wp == rp);
   assign full    = (wp[AW] != rp[AW]) &&
                    (wp[AW-1:0] == rp[AW-1:0]);
   assign dout    = mem[rp[AW-1:0]];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp <= '0;
         rp <= '0;
      end else if (flush) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (do_push) wp <= wp + 1'b1;
         if (do_pop)  rp <= rp + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (do_push && !flush) begin
         mem[wp[AW-1:0]] <= din;
      end
   end

endmodule

// File: rtl/spike_packet_receiver.sv
// Cluster-side spike endpoint: buffer, filter by cluster and neuron,
// map source through a CAM to a synapse slot, emit weighted requests.
module spike_packet_receiver
   import snn_noc_pkg::*;
#(
   parameter logic [7:0] CLUSTER_ID  = 8'h00,
   parameter int         NUM_NEURONS = 10,
   parameter int         SRC_SLOTS   = 16,
   parameter int         FIFO_DEPTH  = 4,
   parameter int         WEIGHT_W    = 16
) (
   input  logic                   CLK,
   input  logic                   RESET_N,
   input  logic                   clear,
   spike_packet_receiver_if.slave bus,
   input  logic                   cfg_we,
   input  logic                   cfg_sel,
   input  logic [7:0]             cfg_addr,
   input  logic [15:0]            cfg_data,
   output logic [15:0]            drop_count,
   output logic                   idle
);

   localparam int SLOT_W = $clog2(SRC_SLOTS);
   localparam int NROWS  = 2 ** NRN_W;

   pkt_t                       head;
   logic                       fifo_full;
   logic                       fifo_empty;
   logic                       push;
   logic                       pop;

   logic                       s1_valid;
   pkt_t                       s1_pkt;
   logic [ADDR_W-1:0]          s1_src;
   logic [ADDR_W-1:0]          s1_dst;
   logic [NRN_W-1:0]           s1_nrn;
   logic                       cluster_hit;
   logic                       idx_ok;
   logic                       s1_ok;
   logic                       s1_drop;
   logic                       s1_adv;
   logic                       s1_take;

   logic                       cam_v [SRC_SLOTS];
   logic [ADDR_W-1:0]          cam_a [SRC_SLOTS];
   logic signed [WEIGHT_W-1:0] wtab  [NROWS][SRC_SLOTS];
   logic                       cam_hit;
   logic [SLOT_W-1:0]          cam_slot;
   logic [SLOT_W-1:0]          cfg_slot;
   logic [NRN_W-1:0]           cfg_nrn;
   logic                       cfg_unused;

   logic                       out_valid;
   logic                       out_free;
   logic [NRN_W-1:0]           out_nrn;
   logic signed [WEIGHT_W-1:0] out_weight;

   assign bus.pkt_ready  = RESET_N && !fifo_full && !clear;
   assign push           = bus.pkt_valid && bus.pkt_ready;

   spike_pkt_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (PKT_W)
   ) u_fifo (
      .clk   (CLK),
      .rst_n (RESET_N),
      .flush (clear),
      .push  (push),
      .pop   (pop),
      .din   (bus.pkt_in),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign s1_src      = pkt_src(s1_pkt);
   assign s1_dst      = pkt_dst(s1_pkt);
   assign s1_nrn      = dst_neuron(s1_dst);
   assign cluster_hit = (dst_cluster(s1_dst) == CLUSTER_ID);
   assign idx_ok      = (32'(s1_nrn) < NUM_NEURONS);

   // Scan high to low so the lowest matching slot is the one kept.
   always_comb begin
      cam_hit  = 1'b0;
      cam_slot = '0;
      for (int i = SRC_SLOTS - 1; i >= 0; i--) begin
         if (cam_v[i] && cam_a[i] == s1_src) begin
            cam_hit  = 1'b1;
            cam_slot = SLOT_W'(i);
         end
      end
   end

   assign s1_ok    = cluster_hit && idx_ok && cam_hit;
   assign s1_drop  = s1_valid && !s1_ok;
   assign out_free = !out_valid || bus.acc_ready;
   // A drop never waits on the output stage.
   assign s1_adv   = s1_valid && (!s1_ok || out_free);
   assign s1_take  = !s1_valid || s1_adv;
   assign pop      = s1_take && !fifo_empty && !clear;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         s1_valid   <= 1'b0;
         s1_pkt     <= '0;
         out_valid  <= 1'b0;
         out_nrn    <= '0;
         out_weight <= '0;
         drop_count <= '0;
      end else if (clear) begin
         s1_valid   <= 1'b0;
         out_valid  <= 1'b0;
         drop_count <= '0;
      end else begin
         if (s1_take) begin
            s1_valid <= !fifo_empty;
            s1_pkt   <= head;
         end
         if (out_free) begin
            out_valid <= s1_valid && s1_ok;
            if (s1_valid && s1_ok) begin
               out_nrn    <= s1_nrn;
               out_weight <= wtab[s1_nrn][cam_slot];
            end
         end
         if (s1_drop && drop_count != 16'hFFFF) begin
            drop_count <= drop_count + 16'd1;
         end
      end
   end

   assign cfg_slot   = cfg_addr[SLOT_W-1:0];
   assign cfg_nrn    = cfg_addr[7:4];
   assign cfg_unused = ^cfg_data[15:13];

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         for (int i = 0; i < SRC_SLOTS; i++) begin
            cam_v[i] <= 1'b0;
            cam_a[i] <= '0;
         end
         for (int n = 0; n < NROWS; n++) begin
            for (int i = 0; i < SRC_SLOTS; i++) wtab[n][i] <= '0;
         end
      end else if (cfg_we) begin
         if (cfg_sel == CFG_CAM) begin
            cam_v[cfg_slot] <= cfg_data[12];
            cam_a[cfg_slot] <= cfg_data[ADDR_W-1:0];
         end else if (32'(cfg_nrn) < NUM_NEURONS) begin
            wtab[cfg_nrn][cfg_slot] <= cfg_data[WEIGHT_W-1:0];
         end
      end
   end

   assign bus.acc_valid  = out_valid;
   assign bus.acc_neuron = out_nrn;
   assign bus.acc_weight = out_weight;
   assign idle = RESET_N && fifo_empty && !s1_valid && !out_valid;

endmodule

// File: tb/tb_spike_packet_receiver.sv
// Self-checking bench for spike_packet_receiver: table vectors,
// backpressure/clear/reset sequences and a randomized model run.
module tb_spike_packet_receiver;

   localparam logic [7:0] CID = 8'h01;
   localparam int         NN  = 10;

   typedef struct {
      logic [23:0]        pkt;
      bit                 use_model;
      bit                 deliver;
      logic [3:0]         neuron;
      logic signed [15:0] weight;
   } vec_t;

   typedef struct {
      logic [3:0]         neuron;
      logic signed [15:0] weight;
   } exp_t;

   logic        CLK = 1'b0;
   logic        RESET_N = 1'b1;
   logic        clear = 1'b0;
   logic        cfg_we = 1'b0;
   logic        cfg_sel = 1'b0;
   logic [7:0]  cfg_addr = '0;
   logic [15:0] cfg_data = '0;
   logic [15:0] drop_count;
   logic        idle;

   spike_packet_receiver_if #(.WEIGHT_W(16)) bus();

   spike_packet_receiver #(
      .CLUSTER_ID  (CID),
      .NUM_NEURONS (NN),
      .SRC_SLOTS   (16),
      .FIFO_DEPTH  (4),
      .WEIGHT_W    (16)
   ) dut (
      .CLK        (CLK),
      .RESET_N    (RESET_N),
      .clear      (clear),
      .bus        (bus),
      .cfg_we     (cfg_we),
      .cfg_sel    (cfg_sel),
      .cfg_addr   (cfg_addr),
      .cfg_data   (cfg_data),
      .drop_count (drop_count),
      .idle       (idle)
   );

   always #5 CLK = ~CLK;

   bit                 mv [16];
   logic [11:0]        ma [16];
   logic signed [15:0] mw [16][16];
   int                 exp_drops = 0;
   vec_t               sendq [$];
   exp_t               expq [$];
   vec_t               vtab [5];
   logic [11:0]        pool [4];

   int vectors = 0;
   int errors  = 0;
   int cyc     = 0;
   int acc_cnt = 0;
   int acc_cyc = 0;
   int del_cyc = 0;
   bit delivered = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)",
                  name, act, req, $time);
      end
   endtask

   task automatic model_reset();
      for (int s = 0; s < 16; s++) begin
         mv[s] = 0;
         ma[s] = '0;
         for (int n = 0; n < 16; n++) mw[n][s] = '0;
      end
      exp_drops = 0;
   endtask

   // Expected outcome of an accepted packet from the plain rules.
   task automatic model_accept(input vec_t v);
      bit   ok;
      int   slot;
      exp_t e;
      e = '{4'd0, 16'sd0};
      if (v.use_model) begin
         slot = -1;
         for (int s = 0; s < 16; s++)
            if (slot < 0 && mv[s] && ma[s] == v.pkt[23:12]) slot = s;
         ok = (v.pkt[11:4] == CID) && (int'(v.pkt[3:0]) < NN)
              && (slot >= 0);
         if (ok) e = '{v.pkt[3:0], mw[v.pkt[3:0]][slot]};
      end else begin
         ok = v.deliver;
         e  = '{v.neuron, v.weight};
      end
      if (ok) expq.push_back(e);
      else if (exp_drops < 65535) exp_drops++;
   endtask

   task automatic drive();
      bus.pkt_valid = (sendq.size() != 0);
      bus.pkt_in    = (sendq.size() != 0) ? sendq[0].pkt : 24'h0;
   endtask

   // One clock: observe at the falling edge, drive after the rising.
   task automatic tick();
      exp_t e;
      @(negedge CLK);
      cyc++;
      delivered = 0;
      if (RESET_N && clear) begin
         expq.delete();
         exp_drops = 0;
      end else if (RESET_N) begin
         if (bus.acc_valid) begin
            if (expq.size() == 0) begin
               chk("unexpected_acc_valid", 32'(bus.acc_valid), 32'd0);
            end else begin
               e = expq[0];
               chk("acc_neuron", 32'(bus.acc_neuron), 32'(e.neuron));
               chk("acc_weight", 32'(bus.acc_weight), 32'(e.weight));
               if (bus.acc_ready) begin
                  void'(expq.pop_front());
                  delivered = 1;
                  del_cyc = cyc;
               end
            end
         end
         if (bus.pkt_valid && bus.pkt_ready) begin
            model_accept(sendq.pop_front());
            acc_cnt++;
            acc_cyc = cyc;
         end
      end
      @(posedge CLK);
      #1;
      drive();
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while (!(sendq.size() == 0 && expq.size() == 0 && idle)
             && n < budget) begin
         tick();
         n++;
      end
      chk("idle", 32'(idle), 32'd1);
      chk("pending_deliveries", 32'(expq.size()), 32'd0);
   endtask

   task automatic cfg_write(input bit sel, input logic [7:0] a,
                            input logic [15:0] d);
      cfg_we   = 1'b1;
      cfg_sel  = sel;
      cfg_addr = a;
      cfg_data = d;
      tick();
      cfg_we = 1'b0;
      if (!sel) begin
         mv[a[3:0]] = d[12];
         ma[a[3:0]] = d[11:0];
      end else if (int'(a[7:4]) < NN) begin
         mw[a[7:4]][a[3:0]] = d;
      end
   endtask

   function automatic vec_t mpkt(input logic [11:0] src,
                                 input logic [11:0] dst);
      return '{{src, dst}, 1'b1, 1'b0, 4'd0, 16'sd0};
   endfunction

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      vtab[0] = '{24'h0A5012, 1'b0, 1'b1, 4'd2, -16'sd7};
      vtab[1] = '{24'h0A5022, 1'b0, 1'b0, 4'd0, 16'sd0};
      vtab[2] = '{24'h0A501C, 1'b0, 1'b0, 4'd0, 16'sd0};
      vtab[3] = '{24'h0B0012, 1'b0, 1'b0, 4'd0, 16'sd0};
      vtab[4] = '{24'h0A5012, 1'b0, 1'b1, 4'd2, 16'sd100};
      pool[0] = 12'h0A5;
      pool[1] = 12'h0B0;
      pool[2] = 12'h123;
      pool[3] = 12'h3FF;
      model_reset();
      bus.acc_ready = 1'b1;
      bus.pkt_valid = 1'b0;
      bus.pkt_in    = '0;

      #1 RESET_N = 1'b0;
      #3;
      chk("rst_pkt_ready", 32'(bus.pkt_ready), 32'd0);
      chk("rst_acc_valid", 32'(bus.acc_valid), 32'd0);
      chk("rst_acc_neuron", 32'(bus.acc_neuron), 32'd0);
      chk("rst_acc_weight", 32'(bus.acc_weight), 32'd0);
      chk("rst_drop_count", 32'(drop_count), 32'd0);
      chk("rst_idle", 32'(idle), 32'd0);
      @(posedge CLK);
      #1 RESET_N = 1'b1;
      #1;
      chk("idle_after_reset", 32'(idle), 32'd1);
      chk("pkt_ready_after_reset", 32'(bus.pkt_ready), 32'd1);

      cfg_write(1'b0, 8'h03, 16'h10A5);
      cfg_write(1'b1, 8'h23, 16'hFFF9);

      for (int i = 0; i < 5; i++) begin
         if (i == 4) begin
            cfg_write(1'b0, 8'h01, 16'h10A5);
            cfg_write(1'b0, 8'h05, 16'h10A5);
            cfg_write(1'b1, 8'h21, 16'd100);
            cfg_write(1'b1, 8'h25, 16'd200);
         end
         acc_cyc = -100;
         del_cyc = -1;
         sendq.push_back(vtab[i]);
         drive();
         wait_idle(20);
         if (i == 0)
            chk("latency_edges", 32'(del_cyc - acc_cyc - 1), 32'd2);
         chk("drop_count", 32'(drop_count), 32'(exp_drops));
      end

      for (int k = 0; k < 8; k++)
         cfg_write(1'b1, {4'(k), 4'd1}, 16'(k * 13 - 40));
      bus.acc_ready = 1'b0;
      for (int k = 0; k < 8; k++)
         sendq.push_back(mpkt(12'h0A5, {CID, 4'(k)}));
      drive();
      acc_cnt = 0;
      repeat (12) tick();
      chk("bp_accepted", 32'(acc_cnt), 32'd6);
      chk("bp_pkt_ready", 32'(bus.pkt_ready), 32'd0);
      chk("bp_acc_valid", 32'(bus.acc_valid), 32'd1);
      bus.acc_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         tick();
         chk("bp_one_per_cycle", 32'(delivered), 32'd1);
      end
      wait_idle(20);

      bus.acc_ready = 1'b0;
      for (int k = 0; k < 3; k++)
         sendq.push_back(mpkt(12'h0A5, {CID, 4'(k)}));
      drive();
      repeat (6) tick();
      chk("pre_clear_drops", 32'(drop_count), 32'(exp_drops));
      sendq.push_back(mpkt(12'h0A5, {CID, 4'd3}));
      drive();
      clear = 1'b1;
      #1;
      chk("clear_pkt_ready", 32'(bus.pkt_ready), 32'd0);
      tick();
      clear = 1'b0;
      chk("clear_acc_valid", 32'(bus.acc_valid), 32'd0);
      chk("clear_drop_count", 32'(drop_count), 32'd0);
      bus.acc_ready = 1'b1;
      wait_idle(20);
      chk("after_clear_drops", 32'(drop_count), 32'd0);

      for (int r = 0; r < 6; r++) begin
         for (int k = 0; k < 4; k++)
            cfg_write(1'b0, 8'($urandom_range(0, 15)),
                      {3'b0, 1'($urandom_range(0, 3) != 0),
                       pool[$urandom_range(0, 3)]});
         for (int k = 0; k < 8; k++)
            cfg_write(1'b1, {4'($urandom_range(0, 11)),
                             4'($urandom_range(0, 15))},
                      16'($urandom));
         for (int p = 0; p < 30; p++)
            sendq.push_back(mpkt(pool[$urandom_range(0, 3)],
               {($urandom_range(0, 3) != 0) ? CID
                                             : 8'($urandom_range(0, 3)),
                4'($urandom_range(0, 15))}));
         drive();
         n = 0;
         while (!(sendq.size() == 0 && expq.size() == 0 && idle)
                && n < 600) begin
            bus.acc_ready = ($urandom_range(0, 3) != 0);
            tick();
            n++;
         end
         bus.acc_ready = 1'b1;
         chk("rand_idle", 32'(idle), 32'd1);
         chk("rand_pending", 32'(expq.size()), 32'd0);
         chk("rand_drop_count", 32'(drop_count), 32'(exp_drops));
      end

      cfg_write(1'b0, 8'h02, 16'h10A5);
      cfg_write(1'b1, 8'h02, 16'd55);
      cfg_write(1'b1, 8'h12, 16'd66);
      cfg_write(1'b1, 8'h22, 16'd77);
      bus.acc_ready = 1'b0;
      for (int k = 0; k < 3; k++)
         sendq.push_back(mpkt(12'h0A5, {CID, 4'(k)}));
      drive();
      repeat (5) tick();
      chk("pre_reset_acc_valid", 32'(bus.acc_valid), 32'd1);
      #2 RESET_N = 1'b0;
      #1;
      chk("async_rst_acc_valid", 32'(bus.acc_valid), 32'd0);
      chk("async_rst_pkt_ready", 32'(bus.pkt_ready), 32'd0);
      chk("async_rst_idle", 32'(idle), 32'd0);
      sendq.delete();
      expq.delete();
      model_reset();
      bus.pkt_valid = 1'b0;
      #2 RESET_N = 1'b1;
      @(posedge CLK);
      #1;
      bus.acc_ready = 1'b1;
      sendq.push_back(mpkt(12'h0A5, {CID, 4'd2}));
      drive();
      wait_idle(20);
      chk("post_reset_cam_miss", 32'(drop_count), 32'd1);
      chk("post_reset_model_drops", 32'(drop_count), 32'(exp_drops));

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, errors);
      $finish;
   end

endmodule

// File: doc/spike_packet_receiver.md
Name: spike_packet_receiver

Overview:
- Destination-side endpoint for the 24-bit spike packets that cluster network interfaces emit: packet = {source neuron address[11:0], destination address[11:0]}.
- Buffers incoming packets and filters out any not addressed to this cluster.
- Resolves the source address to a synapse slot through a small programmable CAM, then reads the synaptic weight.
- Issues one weighted accumulate request per accepted packet to the local neuron accumulators, with valid/ready backpressure.

Parameters:
- CLUSTER_ID, 8'h00, matched against dst[11:4]
- NUM_NEURONS, 10, local neurons; dst[3:0] must be < NUM_NEURONS
- SRC_SLOTS, 16, source CAM entries (power of 2)
- FIFO_DEPTH, 4, input packet buffer depth (power of 2, ≥2)
- WEIGHT_W, 16, signed weight width

Ports:
- CLK  in  1  clock, rising edge
- RESET_N  in  1  asynchronous active-low reset
- clear  in  1  synchronous timestep flush
- pkt_in  in  24  {src[11:0], dst[11:0]}
- pkt_valid  in  1  pkt_in valid
- pkt_ready  out  1  receiver can accept
- cfg_we  in  1  config write strobe
- cfg_sel  in  1  0 = CAM entry, 1 = weight
- cfg_addr  in  8  CAM: slot in [3:0]; weight: {neuron[3:0], slot[3:0]}
- cfg_data  in  16  CAM: {3'b0, valid, src_addr[11:0]}; weight: signed weight
- acc_valid  out  1  accumulate request valid
- acc_ready  in  1  accumulator accepts
- acc_neuron  out  4  target local neuron index
- acc_weight  out  WEIGHT_W  signed weight to add
- drop_count  out  16  packets dropped this timestep, saturating
- idle  out  1  FIFO, S1 and output stage all empty

Behaviour:
- Clock CLK; reset is asynchronous active-low on RESET_N.
- While RESET_N=0:
  - all outputs are 0, including pkt_ready;
  - FIFO pointers, S1 and output valid bits, drop_count, CAM valid bits and weight table are cleared.
- Input handshake:
  - Transfer occurs when pkt_valid && pkt_ready at a rising edge.
  - pkt_ready = !fifo_full && !clear. It has no combinational path from acc_ready.
- Pipeline has three registered stages: FIFO → S1 (decode/match) → OUT (weight).
  - A packet accepted at edge k with an empty pipeline and acc_ready=1 presents acc_valid=1 after edge k+2.
  - Throughput is one packet per cycle.
- S1 loads the FIFO head whenever S1 is empty or advancing. S1 evaluates:
  - cluster_hit = (dst[11:4] == CLUSTER_ID)
  - idx_ok = (dst[3:0] < NUM_NEURONS)
  - CAM match = valid && src_addr == pkt src. With multiple hits, the lowest slot wins.
- S1 → OUT:
  - If all three conditions hold, OUT loads acc_neuron = dst[3:0] and acc_weight = weight[{dst[3:0], slot}].
  - Otherwise the packet is discarded, drop_count increments (saturating at 16'hFFFF), and OUT is not loaded.
- Output handshake:
  - OUT holds acc_neuron and acc_weight stable while acc_valid && !acc_ready.
  - S1 and FIFO stall behind a blocked OUT.
  - A dropping S1 entry is not blocked by OUT: the drop proceeds even if OUT is stalled.
- FIFO boundaries:
  - Full: pkt_ready=0.
  - Empty: S1 is not loaded.
  - Push and pop in the same cycle is legal whenever not full.
  - Pointers wrap modulo FIFO_DEPTH.
- clear=1 at an edge:
  - empties the FIFO, S1 and OUT, so acc_valid=0 after the edge;
  - zeroes drop_count;
  - does not change CAM or weights;
  - a packet offered in the same cycle is not accepted.
- Config writes:
  - Allowed at any time; they take effect from the next edge.
  - A packet in S1 during the write cycle uses the old contents.
  - Weight addresses with neuron ≥ NUM_NEURONS are ignored.
- idle = FIFO empty && !S1 valid && !acc_valid. The controller uses it as the end-of-timestep indicator.
- Reset asserted mid-operation discards all in-flight packets immediately.

Decomposition:
- Shared package snn_noc_pkg:
  - packet field widths and slices: SRC_MSB=23, SRC_LSB=12, DST_MSB=11, DST_LSB=0, CLUSTER field [11:4], NEURON field [3:0];
  - the cfg_sel encodings.
- One sub-module: spike_pkt_fifo, a synchronous FIFO with push/pop/flush and full/empty flags.

Test Plan:
- Reset then program CAM slot 3 = 12'h0A5 (valid) and weight[{4'd2, 4'd3}] = 16'sd-7, with CLUSTER_ID=8'h01. Send 24'h0A5_012 → acc_valid after 2 edges with acc_neuron=2, acc_weight=-7; drop_count=0.
- Send 24'h0A5_022 (wrong cluster), 24'h0A5_01C (idx 12), 24'h0B0_012 (CAM miss) → no acc_valid; drop_count=3; idle=1 afterwards.
- Hold acc_ready=0 and stream 8 valid packets → pkt_ready falls after 6 accepted (4 FIFO + S1 + OUT); acc outputs stay stable. Release acc_ready → all 8 delivered in order, one per cycle.
- Program slots 1 and 5 both = 12'h0A5 with different weights → the slot 1 weight is used.
- With 3 packets in flight, assert clear for 1 cycle while pkt_valid=1 → pkt_ready=0 that cycle; acc_valid=0 next cycle; drop_count=0; CAM and weights retained; a later packet is delivered normally.
- Assert RESET_N=0 asynchronously mid-stream → acc_valid and pkt_ready drop without a clock edge; after release, a CAM miss occurs for a previously programmed address.
